// File: rtl/ucsbece154b_perf_pkg.sv
// rtl/ucsbece154b_perf_pkg.sv - state encoding and read-map layout for the perf monitor
package ucsbece154b_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CYC_SEL  = 0;
  localparam int TOT_BASE = 1;

  function automatic int mis_base(input int n_ch);
    return TOT_BASE + n_ch;
  endfunction

  function automatic int streak_base(input int n_ch);
    return TOT_BASE + 2 * n_ch;
  endfunction

endpackage

// File: rtl/ucsbece154b_perf_monitor_if.sv
// rtl/ucsbece154b_perf_monitor_if.sv - control, event and read-port bundle of the perf monitor
interface ucsbece154b_perf_monitor_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32,
  parameter int SEL_W = 5
);
  logic             start_i;
  logic             clear_i;
  logic [31:0]      stop_pc_i;
  logic [31:0]      pcf_i;
  logic [N_CH-1:0]  ev_valid_i;
  logic [N_CH-1:0]  ev_miss_i;
  logic [SEL_W-1:0] rd_sel_i;
  logic [CNT_W-1:0] rd_data_o;
  logic [1:0]       state_o;
  logic             done_o;
  logic             sat_o;

  modport master (
    output start_i, clear_i, stop_pc_i, pcf_i, ev_valid_i, ev_miss_i, rd_sel_i,
    input  rd_data_o, state_o, done_o, sat_o
  );

  modport slave (
    input  start_i, clear_i, stop_pc_i, pcf_i, ev_valid_i, ev_miss_i, rd_sel_i,
    output rd_data_o, state_o, done_o, sat_o
  );
endinterface

// File: rtl/ucsbece154b_perf_ctr.sv
// rtl/ucsbece154b_perf_ctr.sv - saturating up-counter with synchronous clear
module ucsbece154b_perf_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q,
  output logic             sat
);
  assign sat = &q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !sat) begin
      q <= q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/ucsbece154b_perf_monitor.sv
// rtl/ucsbece154b_perf_monitor.sv - cycle/event/mispredict statistics with registered read port
// Optional miss-streak counters are built when PERF_MON_STREAK_EN is defined.
module ucsbece154b_perf_monitor
  import ucsbece154b_perf_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 500,
  parameter int SEL_W      = 5
) (
  input  logic clk,
  input  logic reset,
  ucsbece154b_perf_monitor_if.slave bus
);
  state_t           state_q, state_d;
  logic             run, stop_hit, limit_hit, any_sat, sat_q, cyc_sat;
  logic [CNT_W-1:0] cyc_q, cyc_after, rd_q, rd_d;
  logic [CNT_W-1:0] tot_q [N_CH];
  logic [CNT_W-1:0] mis_q [N_CH];
  logic [N_CH-1:0]  tot_sat, mis_sat;

  assign run = (state_q == ST_RUN);

  ucsbece154b_perf_ctr #(.CNT_W(CNT_W)) u_cyc (
    .clk(clk), .reset(reset), .clr(bus.clear_i), .inc(run), .q(cyc_q), .sat(cyc_sat)
  );

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    ucsbece154b_perf_ctr #(.CNT_W(CNT_W)) u_tot (
      .clk(clk), .reset(reset), .clr(bus.clear_i),
      .inc(run & bus.ev_valid_i[k]), .q(tot_q[k]), .sat(tot_sat[k])
    );
    ucsbece154b_perf_ctr #(.CNT_W(CNT_W)) u_mis (
      .clk(clk), .reset(reset), .clr(bus.clear_i),
      .inc(run & bus.ev_valid_i[k] & bus.ev_miss_i[k]), .q(mis_q[k]), .sat(mis_sat[k])
    );
  end

`ifdef PERF_MON_STREAK_EN
  logic [CNT_W-1:0] cur_q [N_CH];
  logic [CNT_W-1:0] stk_q [N_CH];
  logic [N_CH-1:0]  cur_sat, stk_sat;

  // streak >= cur always holds, so max(streak, cur+1) only grows when they are equal
  for (genvar k = 0; k < N_CH; k++) begin : g_stk
    ucsbece154b_perf_ctr #(.CNT_W(CNT_W)) u_cur (
      .clk(clk), .reset(reset),
      .clr(bus.clear_i | (run & bus.ev_valid_i[k] & ~bus.ev_miss_i[k])),
      .inc(run & bus.ev_valid_i[k] & bus.ev_miss_i[k]), .q(cur_q[k]), .sat(cur_sat[k])
    );
    ucsbece154b_perf_ctr #(.CNT_W(CNT_W)) u_stk (
      .clk(clk), .reset(reset), .clr(bus.clear_i),
      .inc(run & bus.ev_valid_i[k] & bus.ev_miss_i[k] & (cur_q[k] == stk_q[k])),
      .q(stk_q[k]), .sat(stk_sat[k])
    );
  end

  assign any_sat = cyc_sat | (|tot_sat) | (|mis_sat) | (|cur_sat) | (|stk_sat);
`else
  assign any_sat = cyc_sat | (|tot_sat) | (|mis_sat);
`endif

  assign cyc_after = cyc_sat ? cyc_q : cyc_q + CNT_W'(1);
  assign limit_hit = (MAX_CYCLES != 0) && (64'(cyc_after) == 64'(MAX_CYCLES));
  assign stop_hit  = (bus.pcf_i == bus.stop_pc_i) || limit_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start_i) state_d = ST_RUN;
        ST_RUN:  if (stop_hit) state_d = ST_DONE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    if (int'(bus.rd_sel_i) == CYC_SEL) rd_d = cyc_q;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(bus.rd_sel_i) == TOT_BASE + k) rd_d = tot_q[k];
      if (int'(bus.rd_sel_i) == mis_base(N_CH) + k) rd_d = mis_q[k];
`ifdef PERF_MON_STREAK_EN
      if (int'(bus.rd_sel_i) == streak_base(N_CH) + k) rd_d = stk_q[k];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      sat_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      sat_q <= bus.clear_i ? 1'b0 : (sat_q | any_sat);
    end
  end

  assign bus.rd_data_o = rd_q;
  assign bus.state_o   = state_q;
  assign bus.done_o    = (state_q == ST_DONE);
  assign bus.sat_o     = sat_q;
endmodule
